// File: rtl/meas_result_arbiter_if.sv
// Result bus between the measure channels, the arbiter and the regfile write port.
// The arbiter takes the slave view; the producer/consumer side takes the master view.
interface meas_result_arbiter_if #(
    parameter int N_CH   = 5,
    parameter int DATA_W = 64
);
    localparam int CH_W = $clog2(N_CH);

    logic [N_CH-1:0]              raw_wr_en;
    logic [N_CH-1:0][DATA_W-1:0]  raw_wr_data;
    logic                         reg_wr_rdy;
    logic                         reg_wr_en;
    logic [DATA_W-1:0]            reg_wr_data;
    logic [CH_W-1:0]              reg_wr_ch;

    modport slave (
        input  raw_wr_en,
        input  raw_wr_data,
        input  reg_wr_rdy,
        output reg_wr_en,
        output reg_wr_data,
        output reg_wr_ch
    );

    modport master (
        output raw_wr_en,
        output raw_wr_data,
        output reg_wr_rdy,
        input  reg_wr_en,
        input  reg_wr_data,
        input  reg_wr_ch
    );
endinterface

// File: rtl/meas_result_arbiter.sv
// Buffers one result per measure channel and serialises them onto the single
// regfile write port with round-robin arbitration and sticky overrun flags.
module meas_result_arbiter #(
    parameter int N_CH   = 5,
    parameter int DATA_W = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    meas_result_arbiter_if.slave arb_if,
    input  logic                 ovf_clr_i,
    output logic [N_CH-1:0]      ovf_o
);
    localparam int CH_W = $clog2(N_CH);

    logic [N_CH-1:0][DATA_W-1:0] slot_q;
    logic [N_CH-1:0]             pend_q, pend_d;
    logic [N_CH-1:0]             ovf_q, ovf_d;
    logic [CH_W-1:0]             rr_q, rr_d;
    logic                        en_q, en_d;
    logic [DATA_W-1:0]           data_q, data_d;
    logic [CH_W-1:0]             ch_q, ch_d;

    logic                        out_free;
    logic                        gnt_vld;
    logic                        do_grant;
    logic [CH_W-1:0]             gnt_ch;
    logic [N_CH-1:0]             gnt_oh;
    int                          idx;

    // First pending channel scanning circularly from the round-robin pointer
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        idx     = 0;
        for (int k = 0; k < N_CH; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!gnt_vld && pend_q[idx]) begin
                gnt_vld = 1'b1;
                gnt_ch  = CH_W'(idx);
            end
        end
    end

    assign out_free = !en_q || arb_if.reg_wr_rdy;
    assign do_grant = out_free && gnt_vld;
    assign gnt_oh   = do_grant ? (N_CH'(1) << gnt_ch) : '0;

    always_comb begin
        // A capture on the channel being granted refills its slot without overrun
        pend_d = arb_if.raw_wr_en | (pend_q & ~gnt_oh);
        ovf_d  = (ovf_clr_i ? '0 : ovf_q) | (arb_if.raw_wr_en & pend_q & ~gnt_oh);
        en_d   = en_q;
        data_d = data_q;
        ch_d   = ch_q;
        rr_d   = rr_q;
        if (do_grant) begin
            en_d   = 1'b1;
            data_d = slot_q[gnt_ch];
            ch_d   = gnt_ch;
            rr_d   = (gnt_ch == CH_W'(N_CH - 1)) ? '0 : gnt_ch + 1'b1;
        end else if (out_free) begin
            en_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_q <= '0;
            ovf_q  <= '0;
            rr_q   <= '0;
            en_q   <= 1'b0;
            data_q <= '0;
            ch_q   <= '0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            rr_q   <= rr_d;
            en_q   <= en_d;
            data_q <= data_d;
            ch_q   <= ch_d;
        end
    end

    // Slot contents are qualified by pend_q, so they need no reset
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < N_CH; i++) begin
            if (arb_if.raw_wr_en[i]) slot_q[i] <= arb_if.raw_wr_data[i];
        end
    end

    assign arb_if.reg_wr_en   = en_q;
    assign arb_if.reg_wr_data = data_q;
    assign arb_if.reg_wr_ch   = ch_q;
    assign ovf_o              = ovf_q;
endmodule
